// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: mode encodings and clog2 helper.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Never returns less than 1 so that select ports are always at least one bit wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: grants the first requester strictly after ptr,
// wrapping from NCH-1 back to 0.
module rr_arbiter #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = SEL_W'((int'(ptr) + k) % NCH);
      if (req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// Channel multiplexer with fixed-select or round-robin grant and a registered output stage.
// Optional saturating transfer counter on grant_cnt when CHAN_MUX_RR_STATS_EN is defined.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NCH   = 4,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready,
  output logic [15:0]          grant_cnt
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_vld;
  logic             sel_ok;
  logic             fix_vld;
  logic [SEL_W-1:0] g;
  logic             g_vld;
  logic             load;
  logic             xfer;

  rr_arbiter #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // sel may address a channel that does not exist when NCH is not a power of two.
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(NCH));
  assign fix_vld = sel_ok && in_valid[sel];

  assign g     = (mode == MODE_RR) ? rr_gnt : sel;
  assign g_vld = (mode == MODE_RR) ? rr_vld : fix_vld;

  assign load     = !out_valid || out_ready;
  assign xfer     = g_vld && load && !rst;
  assign in_ready = xfer ? (NCH'(1) << g) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(NCH - 1);
    end else if (load) begin
      out_valid <= g_vld;
      if (g_vld) begin
        out_data <= in_data[int'(g)*WIDTH +: WIDTH];
        out_ch   <= g;
        ptr      <= g;
      end
    end
  end

`ifdef CHAN_MUX_RR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (xfer && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed self-checking bench for chan_mux_rr (WIDTH=8, NCH=4).
module tb_chan_mux_rr;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [15:0] grant_cnt;

  int vecs;
  int errs;

  chan_mux_rr #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ch_data(input int c);
    case (c)
      0: return 8'h10;
      1: return 8'h21;
      2: return 8'hA5;
      default: return 8'h3C;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_data = 32'h3CA52110; in_valid = 4'b1111;
    mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 ||
        grant_cnt !== 16'h0 || in_ready !== 4'b0000) begin
      errs++;
      $display("FAIL reset: v=%b d=%h ch=%0d cnt=%h rdy=%b, want 0/00/0/0000/0000",
               out_valid, out_data, out_ch, grant_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_rr(input logic [3:0] valid, input int exp_seq[8], input string name);
    in_valid = valid; mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vecs++;
      if (in_ready !== (4'b0001 << exp_seq[i])) begin
        errs++;
        $display("FAIL %s rdy[%0d]: got %b want %b", name, i, in_ready, 4'b0001 << exp_seq[i]);
      end
      @(posedge clk); #1;
      vecs++;
      if (out_valid !== 1'b1 || out_ch !== 2'(exp_seq[i]) || out_data !== ch_data(exp_seq[i])) begin
        errs++;
        $display("FAIL %s out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                 name, i, out_valid, out_ch, out_data, exp_seq[i], ch_data(exp_seq[i]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_all();
    int s[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_rr(4'b1111, s, "rr_all");
  endtask

  task automatic test_rr_sparse();
    int s[8] = '{1, 3, 1, 3, 1, 3, 1, 3};
    run_rr(4'b1010, s, "rr_sparse");
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 4'b0100) begin
      errs++; $display("FAIL fixed_rdy: got %b want 0100", in_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errs++; $display("FAIL fixed_out: got v=%b d=%h ch=%0d want 1/a5/2", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    // Selected channel not valid: no grant, output drains, data/ch hold.
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    vecs++;
    if (in_ready !== 4'b0000) begin
      errs++; $display("FAIL fixed_idle_rdy: got %b want 0000", in_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      errs++; $display("FAIL fixed_idle_out: got v=%b d=%h ch=%0d want 0/a5/2", out_valid, out_data, out_ch);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    // ptr is 2 after the fixed test, so round-robin picks channel 3 next.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h3C) begin
      errs++; $display("FAIL bp_first: got v=%b ch=%0d d=%h want 1/3/3c", out_valid, out_ch, out_data);
    end
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (in_ready !== 4'b0000) begin
        errs++; $display("FAIL bp_rdy[%0d]: got %b want 0000", i, in_ready);
      end
      @(posedge clk); #1;
      vecs++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h3C) begin
        errs++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h want 1/3/3c", i, out_valid, out_ch, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 4'b0001) begin
      errs++; $display("FAIL bp_release_rdy: got %b want 0001", in_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
      errs++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%h want 1/0/10", out_valid, out_ch, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 ||
        grant_cnt !== 16'h0 || in_ready !== 4'b0000) begin
      errs++;
      $display("FAIL mid_reset: v=%b d=%h ch=%0d cnt=%h rdy=%b want 0/00/0/0000/0000",
               out_valid, out_data, out_ch, grant_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    #1;
    vecs++;
    if (in_ready !== 4'b0001) begin
      errs++; $display("FAIL ptr_after_reset: got %b want 0001", in_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
      errs++; $display("FAIL first_after_reset: got v=%b ch=%0d want 1/0", out_valid, out_ch);
    end
    @(negedge clk);
  endtask

  task automatic test_stats();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
`ifdef CHAN_MUX_RR_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vecs++;
    if (grant_cnt !== 16'd5) begin
      errs++; $display("FAIL stats_5: got %h want 0005", grant_cnt);
    end
    repeat (69995) @(posedge clk);
    #1;
    vecs++;
    if (grant_cnt !== 16'hFFFF) begin
      errs++; $display("FAIL stats_sat: got %h want ffff", grant_cnt);
    end
`else
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (grant_cnt !== 16'h0000) begin
        errs++; $display("FAIL stats_off[%0d]: got %h want 0000", i, grant_cnt);
      end
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_fixed();
    test_backpressure();
    test_midstream_reset();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
